// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, counter encodings and address-split helpers
//               for the dynamic branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default configuration, matching the top-level parameter defaults.
  localparam int BP_ADDR_W  = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CTR_W   = 2;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_ADDR_W - 2 - BP_IDX_W;

  // Direction counter encodings for a 2-bit counter.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

  // One BTB entry in the default configuration. The top re-declares the same
  // layout at its own parameterised widths.
  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_W-1:0]   tag;
    logic [BP_ADDR_W-3:0]  target;
    logic [BP_CTR_W-1:0]   ctr;
  } bp_entry_t;

  // Counter value after reset: weakly not-taken.
  function automatic int ctr_reset_val(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Counter value for a freshly allocated entry: weakly taken.
  function automatic int ctr_alloc_val(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Lowest PC bit of the index field (bits [1:0] are the byte offset).
  function automatic int idx_lsb();
    return 2;
  endfunction

  // Lowest PC bit of the tag field.
  function automatic int tag_lsb(input int idx_w);
    return idx_w + 2;
  endfunction

  // Tag width left over once byte offset and index are removed.
  function automatic int tag_width(input int addr_w, input int idx_w);
    return addr_w - 2 - idx_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Next-value logic for a saturating up/down direction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             inc,
  input  logic             en,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

  // Step towards taken or not-taken, holding at either end of the range.
  always_comb begin
    nxt = cur;
    if (en) begin
      if (inc) begin
        if (cur != CTR_MAX) nxt = cur + CTR_W'(1);
      end else begin
        if (cur != CTR_MIN) nxt = cur - CTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with per-entry saturating direction
//               counters. Combinational lookup for IF, registered update
//               from ID, plus lookup and mispredict performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              flush_all_i,
  output logic [CNT_W-1:0]  lookup_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = tag_width(ADDR_W, IDX_W);
  localparam int IDX_LSB = idx_lsb();
  localparam int TAG_LSB = tag_lsb(IDX_W);

  localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-3:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  entry_t             table_q [ENTRIES];
  logic [CNT_W-1:0]   lookup_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_q;

  // Lookup side
  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  entry_t             lk_entry;
  logic               lk_hit;
  logic               lk_taken;

  // Update side
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  entry_t             upd_entry;
  logic               upd_hit;
  logic [CTR_W-1:0]   ctr_next;

  // Byte-offset bits of the update addresses carry no information.
  logic               unused_offset_bits;
  assign unused_offset_bits = ^{upd_pc_i[1:0], upd_target_i[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign lk_idx       = pc_i[TAG_LSB-1:IDX_LSB];
  assign lk_tag       = pc_i[ADDR_W-1:TAG_LSB];
  assign lk_entry     = table_q[lk_idx];
  assign lk_hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken     = lk_hit && lk_entry.ctr[CTR_W-1];
  assign hit_o        = lk_hit;
  assign pred_taken_o = lk_taken;
  assign next_pc_o    = lk_taken ? {lk_entry.target, 2'b00} : pc_i + ADDR_W'(4);

  assign upd_idx   = upd_pc_i[TAG_LSB-1:IDX_LSB];
  assign upd_tag   = upd_pc_i[ADDR_W-1:TAG_LSB];
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  bp_sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .cur (upd_entry.ctr),
    .inc (upd_taken_i),
    .en  (upd_hit),
    .nxt (ctr_next)
  );

  // Table maintenance: reset, then flush, then resolved-branch update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (flush_all_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        table_q[upd_idx].ctr <= ctr_next;
        if (upd_taken_i) table_q[upd_idx].target <= upd_target_i[ADDR_W-1:2];
      end else if (upd_taken_i) begin
        table_q[upd_idx] <= '{valid:  1'b1,
                              tag:    upd_tag,
                              target: upd_target_i[ADDR_W-1:2],
                              ctr:    CTR_ALLOC};
      end
    end
  end

  // Free-running performance counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (lookup_valid_i)              lookup_cnt_q  <= lookup_cnt_q + CNT_W'(1);
      if (upd_valid_i && upd_mispred_i) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign lookup_cnt_o  = lookup_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              lookup_valid_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] next_pc_o;
  logic              upd_valid_i = 1'b0;
  logic [ADDR_W-1:0] upd_pc_i = '0;
  logic              upd_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_target_i = '0;
  logic              upd_mispred_i = 1'b0;
  logic              flush_all_i = 1'b0;
  logic [CNT_W-1:0]  lookup_cnt_o;
  logic [CNT_W-1:0]  mispred_cnt_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lookup_valid_i (lookup_valid_i),
    .pc_i           (pc_i),
    .hit_o          (hit_o),
    .pred_taken_o   (pred_taken_o),
    .next_pc_o      (next_pc_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .upd_mispred_i  (upd_mispred_i),
    .flush_all_i    (flush_all_i),
    .lookup_cnt_o   (lookup_cnt_o),
    .mispred_cnt_o  (mispred_cnt_o)
  );

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lk = '0;
  logic [15:0] m_mp = '0;

  // Drive a lookup and record what the predictor must answer.
  task automatic drive_lookup(input string tag, input logic [31:0] pc,
                              input logic hit, input logic taken, input logic [31:0] npc);
    exp_t e;
    lookup_valid_i = 1'b1;
    pc_i           = pc;
    e.tag = tag; e.hit = hit; e.taken = taken; e.npc = npc;
    sbq.push_back(e);
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic mis);
    upd_valid_i   = 1'b1;
    upd_pc_i      = pc;
    upd_taken_i   = taken;
    upd_target_i  = tgt;
    upd_mispred_i = mis;
  endtask

  // Pop pending expectations and compare against the live lookup outputs.
  task automatic check_outputs();
    exp_t e;
    @(negedge clk_i);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      assert (hit_o === e.hit) else begin
        errors++;
        $error("FAIL %s.hit observed=%0b expected=%0b", e.tag, hit_o, e.hit);
      end
      checks++;
      assert (pred_taken_o === e.taken) else begin
        errors++;
        $error("FAIL %s.taken observed=%0b expected=%0b", e.tag, pred_taken_o, e.taken);
      end
      checks++;
      assert (next_pc_o === e.npc) else begin
        errors++;
        $error("FAIL %s.next_pc observed=%h expected=%h", e.tag, next_pc_o, e.npc);
      end
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check this cycle, advance the counter model, then idle inputs.
  task automatic step();
    check_outputs();
    if (rst_i) begin
      m_lk = '0;
      m_mp = '0;
    end else begin
      if (lookup_valid_i) m_lk = m_lk + 16'd1;
      if (upd_valid_i && upd_mispred_i) m_mp = m_mp + 16'd1;
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; lookup_valid_i = 1'b0; upd_valid_i = 1'b0;
    upd_taken_i = 1'b0; upd_mispred_i = 1'b0; flush_all_i = 1'b0;
  endtask

  initial begin
    // Reset
    rst_i = 1'b1; step();
    rst_i = 1'b1; step();
    check_cnt("rst_lookup_cnt", lookup_cnt_o, 16'd0);
    check_cnt("rst_mispred_cnt", mispred_cnt_o, 16'd0);
    drive_lookup("rst_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
    step();
    check_cnt("first_lookup_cnt", lookup_cnt_o, 16'd1);

    // Allocate with same-cycle lookup: read-before-write
    drive_update(32'h40, 1'b1, 32'h100, 1'b1);
    drive_lookup("same_cycle_miss", 32'h40, 1'b0, 1'b0, 32'h44);
    step();
    drive_lookup("alloc_hit", 32'h40, 1'b1, 1'b1, 32'h100);
    drive_update(32'h40, 1'b0, 32'h0, 1'b1);              // ctr 10 -> 01
    step();
    drive_lookup("walk_01", 32'h40, 1'b1, 1'b0, 32'h44);
    drive_update(32'h40, 1'b0, 32'h0, 1'b0);              // 01 -> 00
    step();
    drive_lookup("walk_00", 32'h40, 1'b1, 1'b0, 32'h44);
    drive_update(32'h40, 1'b0, 32'h0, 1'b0);              // 00 stays 00
    step();
    drive_lookup("walk_00_sat", 32'h40, 1'b1, 1'b0, 32'h44);
    drive_update(32'h40, 1'b1, 32'h100, 1'b1);            // 00 -> 01
    step();
    drive_lookup("walk_up_01", 32'h40, 1'b1, 1'b0, 32'h44);
    drive_update(32'h40, 1'b1, 32'h100, 1'b1);            // 01 -> 10
    step();
    drive_lookup("walk_up_10", 32'h40, 1'b1, 1'b1, 32'h100);
    step();
    check_cnt("walk_mispred_cnt", mispred_cnt_o, m_mp);

    // Aliasing at index 0
    drive_lookup("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
    drive_update(32'h80, 1'b0, 32'h0, 1'b0);
    step();
    drive_lookup("alias_nt_unchanged", 32'h40, 1'b1, 1'b1, 32'h100);
    drive_update(32'h80, 1'b1, 32'h200, 1'b1);
    step();
    drive_lookup("alias_new_hit", 32'h80, 1'b1, 1'b1, 32'h200);
    step();
    drive_lookup("alias_old_miss", 32'h40, 1'b0, 1'b0, 32'h44);
    drive_update(32'h80, 1'b1, 32'h300, 1'b1);            // hit taken: retarget, ctr 11
    step();
    drive_lookup("retarget", 32'h80, 1'b1, 1'b1, 32'h300);
    drive_update(32'h80, 1'b1, 32'h300, 1'b0);            // 11 saturates
    step();
    drive_update(32'h80, 1'b0, 32'h0, 1'b0);              // 11 -> 10, still taken
    step();
    drive_lookup("top_sat", 32'h80, 1'b1, 1'b1, 32'h300);
    drive_lookup("ignore_low_bits", 32'h83, 1'b1, 1'b1, 32'h300);
    step();

    // Flush beats same-cycle update
    drive_update(32'h40, 1'b1, 32'h500, 1'b0);
    step();
    flush_all_i = 1'b1;
    drive_update(32'h80, 1'b1, 32'h400, 1'b0);
    step();
    drive_lookup("flush_miss_80", 32'h80, 1'b0, 1'b0, 32'h84);
    step();
    drive_lookup("flush_miss_40", 32'h40, 1'b0, 1'b0, 32'h44);
    step();
    check_cnt("model_lookup_cnt", lookup_cnt_o, m_lk);
    check_cnt("model_mispred_cnt", mispred_cnt_o, m_mp);

    // Performance counters from a clean start
    rst_i = 1'b1; step();
    drive_lookup("perf_a", 32'h1000, 1'b0, 1'b0, 32'h1004);
    drive_update(32'h2000, 1'b0, 32'h0, 1'b1);
    step();
    drive_lookup("perf_b", 32'h1004, 1'b0, 1'b0, 32'h1008);
    drive_update(32'h2000, 1'b0, 32'h0, 1'b0);
    step();
    drive_lookup("perf_c", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step();
    check_cnt("perf_lookup_cnt", lookup_cnt_o, 16'd3);
    check_cnt("perf_mispred_cnt", mispred_cnt_o, 16'd1);

    // Wrap both counters
    rst_i = 1'b1; step();
    for (int i = 0; i < 65535; i++) begin
      lookup_valid_i = 1'b1;
      drive_update(32'h1000, 1'b0, 32'h0, 1'b1);
      step();
    end
    check_cnt("pre_wrap_lookup_cnt", lookup_cnt_o, 16'hFFFF);
    check_cnt("pre_wrap_mispred_cnt", mispred_cnt_o, 16'hFFFF);
    lookup_valid_i = 1'b1;
    drive_update(32'h1000, 1'b0, 32'h0, 1'b1);
    step();
    check_cnt("wrap_lookup_cnt", lookup_cnt_o, 16'h0000);
    check_cnt("wrap_mispred_cnt", mispred_cnt_o, 16'h0000);

    // Flush leaves counters alone
    flush_all_i = 1'b1;
    lookup_valid_i = 1'b1;
    drive_update(32'h1000, 1'b0, 32'h0, 1'b1);
    step();
    check_cnt("flush_keeps_lookup_cnt", lookup_cnt_o, 16'd1);
    check_cnt("flush_keeps_mispred_cnt", mispred_cnt_o, 16'd1);

    // Reset mid-run drops the same-cycle update and clears the counters
    drive_update(32'h40, 1'b1, 32'h100, 1'b0);
    step();
    rst_i = 1'b1;
    drive_lookup("pre_rst_hit", 32'h40, 1'b1, 1'b1, 32'h100);
    drive_update(32'h80, 1'b1, 32'h200, 1'b1);
    step();
    check_cnt("mid_rst_lookup_cnt", lookup_cnt_o, 16'd0);
    check_cnt("mid_rst_mispred_cnt", mispred_cnt_o, 16'd0);
    drive_lookup("post_rst_40", 32'h40, 1'b0, 1'b0, 32'h44);
    step();
    drive_lookup("post_rst_80", 32'h80, 1'b0, 1'b0, 32'h84);
    step();
    check_cnt("final_lookup_cnt", lookup_cnt_o, m_lk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
